regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port among several writeback sources (ALU, load/store unit, CSR/debug) using round-robin arbitration with a valid/ready handshake per source. It registers the granted write for one cycle before it drives the register file write port. It also keeps a 32-entry pending-write scoreboard so issue logic can stall on registers whose producer has not yet written back. It sits between the execution units and the register file.

## Interface

Parameters:
- NREQ, 3: number of writeback requesters (2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  grant to requester i; the handshake completes when valid and ready are both high at a rising edge.
- req_addr  in  5*NREQ  destination register of requester i, in bits [5i+4:5i].
- req_data  in  32*NREQ  write data of requester i, in bits [32i+31:32i].
- issue_valid  in  1  the issue stage dispatches an instruction with a destination register.
- issue_addr  in  5  that destination register.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- pending_mask  out  32  bit r is set while register r has an issued but uncommitted write.

## Operation

Arbitration:
- A round-robin pointer `last` holds the index of the most recently granted requester.
- Candidate priority order is last+1, last+2, …, wrapping modulo NREQ.
- req_ready is combinational. At most one bit is high: the first valid requester in priority order.
- req_ready is never high for a requester whose valid is low.
- When a handshake occurs, `last` takes the granted index. With no handshake, `last` holds.
- The write port is always free, so one write is accepted every cycle if any request is valid. No backpressure source exists.

Output stage:
- On a handshake from requester g:
  - rf_waddr <= req_addr[g]
  - rf_wdata <= req_data[g]
  - rf_we <= (req_addr[g] != 0)
- A write to x0 is accepted and consumed, but never asserts rf_we.
- With no handshake, rf_we <= 0, and rf_waddr and rf_wdata hold their previous values.

Scoreboard:
- Set: issue_valid && issue_addr != 0 sets pending_mask[issue_addr].
- Clear: rf_we clears pending_mask[rf_waddr] at the same edge at which the register file captures the write.
- Set and clear of the same register at the same edge: the set wins, because a newer producer exists.
- A set and a clear of different registers at the same edge both take effect.
- Bit 0 is constant 0.

Reset:
- While rst=0 at a rising edge: rf_we=0, rf_waddr=0, rf_wdata=0, pending_mask=0, and last=NREQ-1, so requester 0 has first priority after reset.
- req_ready is forced to 0 during reset.
- A reset asserted mid-operation discards the staged write. That write's rf_we does not assert after reset.

## Timing

- Handshake at edge E: rf_we/rf_waddr/rf_wdata are valid during cycle E..E+1. The register file writes at edge E+1, and the pending bit clears at E+1.
- End-to-end latency is one cycle from acceptance to write-port drive. The register file contents update two edges after the request is presented with ready.
- Sustained throughput is one write per cycle.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- pending_mask is registered. The value set by an issue is visible from the cycle after the issuing edge.

## Test plan

- **Reset:** hold rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, rf_we=0, pending_mask=0. Release -> the first grant goes to requester 0.
- **Round-robin:** NREQ=3, all valid continuously, addresses 1/2/3 -> grant sequence 0,1,2,0,1,2. rf_waddr sequence 1,2,3,… one cycle behind the grants, with rf_we=1 every cycle.
- **Sparse requests:** only requester 2 valid, addr 5, data 0xDEADBEEF -> granted immediately. rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF for exactly one cycle, then rf_we=0.
- **x0 write:** requester 1 valid, addr 0 -> req_ready[1]=1, rf_we stays 0, pending_mask unchanged.
- **Scoreboard:**
  - issue addr 7 -> pending_mask[7]=1.
  - Writeback to 7 -> bit 7 clears at the edge where rf_we=1.
  - Issue 7 at the same edge as the rf_we to 7 -> bit 7 remains 1.
- **Mid-operation reset:** accept a write to addr 9, then assert rst at the next edge -> rf_we never goes high for addr 9, and pending_mask=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// one-cycle registered write stage and a 32-entry pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_addr,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [31:0]       pending_mask
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LW-1:0] last;
  logic [LW-1:0] cand;
  logic [LW-1:0] gnt_idx;
  logic          gnt_any;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;
  logic          we_q;
  logic [31:0]   pending_next;

  // Scan last+1 .. last+NREQ (mod NREQ); the first valid requester wins.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = LW'((32'(last) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!rst) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == LW'(i)) begin
        req_ready[i] = gnt_any;
        sel_addr     = req_addr[5*i +: 5];
        sel_data     = req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last     <= LW'(NREQ - 1);
      we_q     <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt_any) begin
      last     <= gnt_idx;
      we_q     <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      we_q     <= 1'b0;
    end
  end

  // A staged write is dropped the moment reset asserts, before the
  // register file can capture it at the next edge.
  assign rf_we = we_q & rst;

  always_comb begin
    pending_next = pending_mask;
    if (rf_we) begin
      pending_next[rf_waddr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      pending_next[issue_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_mask <= '0;
    end else begin
      pending_mask <= pending_next;
    end
  end

endmodule
